// File: rtl/clk_period_meas_if.sv
// Result handshake between clk_period_meas (master) and its consumer (slave).
interface clk_period_meas_if;
  logic        meas_ack;
  logic [31:0] meas_count;
  logic        meas_valid;
  logic        meas_overrun;
  logic        meas_timeout;

  modport master (
    input  meas_ack,
    output meas_count,
    output meas_valid,
    output meas_overrun,
    output meas_timeout
  );

  modport slave (
    output meas_ack,
    input  meas_count,
    input  meas_valid,
    input  meas_overrun,
    input  meas_timeout
  );
endinterface

// File: rtl/clk_period_meas.sv
// Measures edge-to-edge intervals of an asynchronous slow input in clk cycles.
// Define CLK_MEAS_FULL_PERIOD_EN to count rising edges only (full period).
module clk_period_meas #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] TIMEOUT     = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              clk_rst,
  input  logic              sig_in,
  clk_period_meas_if.master meas
);

  typedef enum logic [1:0] {StIdle, StArm, StCount} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [31:0]            cnt_q;
  state_e                 state_q;
  logic                   sync_out;
  logic                   e;

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef CLK_MEAS_FULL_PERIOD_EN
  assign e = sync_out & ~hist_q;
`else
  assign e = sync_out ^ hist_q;
`endif

  always_ff @(posedge clk) begin
    if (clk_rst) begin
      sync_q            <= '0;
      hist_q            <= 1'b0;
      cnt_q             <= '0;
      state_q           <= StIdle;
      meas.meas_count   <= '0;
      meas.meas_valid   <= 1'b0;
      meas.meas_overrun <= 1'b0;
      meas.meas_timeout <= 1'b0;
    end else begin
      sync_q            <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q            <= sync_out;
      meas.meas_timeout <= 1'b0;
      // A publish in the same cycle below overrides this clear.
      if (meas.meas_valid && meas.meas_ack) begin
        meas.meas_valid <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          // First edge may be a synchronizer reset artefact; only arm on it.
          if (e) begin
            state_q <= StArm;
            cnt_q   <= 32'd1;
          end
        end
        StArm: begin
          if (e) begin
            state_q <= StCount;
            cnt_q   <= 32'd1;
          end else if (cnt_q == TIMEOUT) begin
            meas.meas_timeout <= 1'b1;
            state_q           <= StIdle;
            cnt_q             <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StCount: begin
          if (e) begin
            cnt_q <= 32'd1;
            if (!meas.meas_valid || meas.meas_ack) begin
              meas.meas_count <= cnt_q;
              meas.meas_valid <= 1'b1;
            end else begin
              meas.meas_overrun <= 1'b1;
            end
          end else if (cnt_q == TIMEOUT) begin
            meas.meas_timeout <= 1'b1;
            state_q           <= StIdle;
            cnt_q             <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meas.sv
// Directed bench for clk_period_meas (TIMEOUT = 20, SYNC_STAGES = 2).
module tb_clk_period_meas;

  localparam int unsigned SYNC = 2;
  localparam int unsigned TMO  = 20;

  logic clk;
  logic clk_rst;
  logic sig_in;
  int   n_cmp;
  int   n_err;
  int   to_total;

  clk_period_meas_if m ();

  clk_period_meas #(
    .SYNC_STAGES (SYNC),
    .TIMEOUT     (32'(TMO))
  ) dut (
    .clk     (clk),
    .clk_rst (clk_rst),
    .sig_in  (sig_in),
    .meas    (m.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial to_total = 0;
  always @(negedge clk) if (m.meas_timeout) to_total++;

  typedef struct {
    int gap;
    int edges;
    bit exp_valid;
    int exp_count;
  } vec_t;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Produces one detected edge now; in rising-only builds the input falls back 2 cycles later.
  task automatic make_edge();
`ifdef CLK_MEAS_FULL_PERIOD_EN
    sig_in = 1'b1;
    fork
      begin
        repeat (2) @(posedge clk);
        #1 sig_in = 1'b0;
      end
    join_none
`else
    sig_in = ~sig_in;
`endif
  endtask

  task automatic do_reset();
    sig_in    = 1'b0;
    m.meas_ack = 1'b0;
    clk_rst   = 1'b1;
    cyc(2);
    clk_rst   = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    int first_to;
    int to_hi;
    int snap;
    logic [31:0] v;

    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{gap: 5,  edges: 2, exp_valid: 1'b0, exp_count: 0};
    vecs[1] = '{gap: 5,  edges: 3, exp_valid: 1'b1, exp_count: 5};
    vecs[2] = '{gap: 5,  edges: 6, exp_valid: 1'b1, exp_count: 5};
    vecs[3] = '{gap: 3,  edges: 3, exp_valid: 1'b1, exp_count: 3};
    vecs[4] = '{gap: 9,  edges: 4, exp_valid: 1'b1, exp_count: 9};
    vecs[5] = '{gap: 4,  edges: 1, exp_valid: 1'b0, exp_count: 0};
    vecs[6] = '{gap: 7,  edges: 5, exp_valid: 1'b1, exp_count: 7};
    vecs[7] = '{gap: 12, edges: 3, exp_valid: 1'b1, exp_count: 12};

    sig_in     = 1'b0;
    m.meas_ack = 1'b0;
    clk_rst    = 1'b1;
    cyc(2);
    chk("rst_count", m.meas_count, 32'd0);
    chk("rst_valid", 32'(m.meas_valid), 32'd0);
    chk("rst_overrun", 32'(m.meas_overrun), 32'd0);
    chk("rst_timeout", 32'(m.meas_timeout), 32'd0);
    clk_rst = 1'b0;

    // Table: ack held high, check the cycle right after the last edge's publish.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      m.meas_ack = 1'b1;
      for (int k = 0; k < vecs[i].edges; k++) begin
        make_edge();
        if (k == vecs[i].edges - 1) cyc(SYNC + 1);
        else cyc(vecs[i].gap);
      end
      chk($sformatf("vec%0d_valid", i), 32'(m.meas_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_count", i), m.meas_count, 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_overrun", i), 32'(m.meas_overrun), 32'd0);
      cyc(2);
    end

    // Overrun with ack held low, then release via one ack pulse.
    do_reset();
    make_edge(); cyc(7);
    make_edge(); cyc(7);
    make_edge(); cyc(3);
    chk("ovr_first_valid", 32'(m.meas_valid), 32'd1);
    chk("ovr_first_count", m.meas_count, 32'd7);
    chk("ovr_first_flag", 32'(m.meas_overrun), 32'd0);
    cyc(4);
    make_edge(); cyc(6);
    chk("ovr_flag", 32'(m.meas_overrun), 32'd1);
    chk("ovr_held_count", m.meas_count, 32'd7);
    chk("ovr_held_valid", 32'(m.meas_valid), 32'd1);
    m.meas_ack = 1'b1; cyc(1); m.meas_ack = 1'b0;
    chk("ovr_ack_clears", 32'(m.meas_valid), 32'd0);
    make_edge(); cyc(3);
    chk("ovr_next_valid", 32'(m.meas_valid), 32'd1);
    chk("ovr_next_count", m.meas_count, 32'd7);
    chk("ovr_sticky", 32'(m.meas_overrun), 32'd1);

    // Ack coincident with a publish: new value lands, valid stays, no overrun.
    do_reset();
    make_edge(); cyc(5);
    make_edge(); cyc(5);
    make_edge(); cyc(3);
    chk("sim_first_count", m.meas_count, 32'd5);
    cyc(3);
    make_edge(); cyc(2);
    m.meas_ack = 1'b1; cyc(1); m.meas_ack = 1'b0;
    chk("sim_valid", 32'(m.meas_valid), 32'd1);
    chk("sim_count", m.meas_count, 32'd6);
    chk("sim_overrun", 32'(m.meas_overrun), 32'd0);
    cyc(2);
    chk("sim_stable_valid", 32'(m.meas_valid), 32'd1);
    chk("sim_stable_count", m.meas_count, 32'd6);

    // Timeout: pulse TIMEOUT cycles after the last internal edge (SYNC+1 after the input).
    do_reset();
    m.meas_ack = 1'b1;
    make_edge(); cyc(4);
    make_edge(); cyc(4);
    make_edge();
    first_to = 0;
    to_hi    = 0;
    for (int n = 1; n <= 40; n++) begin
      cyc(1);
      if (m.meas_timeout) begin
        to_hi++;
        if (first_to == 0) first_to = n;
      end
    end
    chk("tmo_latency", 32'(first_to), 32'(SYNC + 1 + TMO));
    chk("tmo_width", 32'(to_hi), 32'd1);
    chk("tmo_valid", 32'(m.meas_valid), 32'd0);
    make_edge(); cyc(4);
    make_edge(); cyc(4);
    chk("tmo_resume_2edges", 32'(m.meas_valid), 32'd0);
    make_edge(); cyc(3);
    chk("tmo_resume_valid", 32'(m.meas_valid), 32'd1);
    chk("tmo_resume_count", m.meas_count, 32'd4);

    // Reset in COUNT with valid and overrun set.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      make_edge(); cyc(5);
    end
    chk("mid_pre_overrun", 32'(m.meas_overrun), 32'd1);
    chk("mid_pre_valid", 32'(m.meas_valid), 32'd1);
    clk_rst = 1'b1; cyc(1); clk_rst = 1'b0;
    chk("mid_rst_count", m.meas_count, 32'd0);
    chk("mid_rst_valid", 32'(m.meas_valid), 32'd0);
    chk("mid_rst_overrun", 32'(m.meas_overrun), 32'd0);
    chk("mid_rst_timeout", 32'(m.meas_timeout), 32'd0);
    m.meas_ack = 1'b1;
    make_edge(); cyc(3);
    make_edge(); cyc(3);
    chk("mid_2edges_valid", 32'(m.meas_valid), 32'd0);
    make_edge(); cyc(3);
    chk("mid_third_valid", 32'(m.meas_valid), 32'd1);
    chk("mid_third_count", m.meas_count, 32'd3);

    // Rate change 6 -> 9 without reset.
    do_reset();
    m.meas_ack = 1'b1;
    snap = to_total;
    for (int k = 0; k < 4; k++) begin
      make_edge(); cyc(6);
    end
    for (int k = 0; k < 4; k++) begin
      make_edge(); cyc(3);
      v = m.meas_count;
      chk($sformatf("rate_valid%0d", k), 32'(m.meas_valid), 32'd1);
      if (k == 0) chk("rate_transitional", 32'(v >= 32'd6 && v <= 32'd9), 32'd1);
      else chk($sformatf("rate_steady%0d", k), v, 32'd9);
      cyc(6);
    end
    chk("rate_no_overrun", 32'(m.meas_overrun), 32'd0);
    chk("rate_no_timeout", 32'(to_total - snap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clk_period_meas.md
# clk_period_meas

Measures the timing of a slow, asynchronous clock-like input in units of the fast system clock. This is the receiving end of a divided clock: driving it with a divider output configured for count N gives a measured value of N. The block sits beside the clock divider in the video/game-tick path. It is used for self-test of tick rates and for recovering the rate of externally supplied slow clocks. Results go to the consumer through a valid/ack handshake, with overrun and timeout reporting.

## Interface
- SYNC_STAGES, 2, number of synchronizer flops on sig_in; legal range 2..4.
- TIMEOUT, 32'hFFFF_FFFF, count at which a missing edge is declared; must be ≥ 2.

- clk  in  1  system clock; all logic on the rising edge.
- clk_rst  in  1  synchronous, active-high reset.
- sig_in  in  1  asynchronous slow input being measured.
- meas_ack  in  1  consumer accepts the current result.
- meas_count  out  32  measured interval in clk cycles.
- meas_valid  out  1  meas_count holds an unconsumed result.
- meas_overrun  out  1  sticky; a result was dropped while meas_valid was high.
- meas_timeout  out  1  one-cycle pulse; no edge seen within TIMEOUT cycles.

## Operation
- sig_in passes through a SYNC_STAGES flop chain and one extra history flop. The edge pulse e is (sync_out XOR history).
  - Default build: both edges count.
  - See Configuration for rising-only mode.
- Interval counter cnt is 32 bits wide.
  - On e, cnt loads 1.
  - Otherwise cnt increments.
  - cnt never wraps, because the timeout fires first.
- State machine:
  - IDLE: e moves to ARM. The first edge is discarded because it may be a reset artefact of the synchronizer.
  - ARM: e moves to COUNT and cnt loads 1.
  - COUNT, on e: publish cnt, cnt loads 1, stay in COUNT.
  - COUNT, no e, cnt == TIMEOUT: pulse meas_timeout, go to IDLE, clear cnt.
  - ARM, no e, cnt == TIMEOUT: same timeout behaviour as COUNT.
  - ARM uses cnt for its timeout.
- Publish:
  - If meas_valid is 0, or meas_ack is 1 in the same cycle: meas_count <= cnt and meas_valid <= 1.
  - Otherwise the result is dropped, meas_count is unchanged, and meas_overrun <= 1.
- Ack:
  - meas_ack with meas_valid high and no simultaneous publish clears meas_valid on the next edge.
  - meas_ack while meas_valid is low is ignored.
- meas_overrun clears only on clk_rst.
- Reset (including mid-measurement), on the next rising clk:
  - sync chain, history flop and cnt are all 0;
  - state is IDLE;
  - meas_count = 0, meas_valid = 0, meas_overrun = 0, meas_timeout = 0.

## Timing
- Sync latency: a sig_in transition produces e SYNC_STAGES+1 cycles later. The interval measurement itself is unaffected.
- Publish latency: meas_valid and meas_count update on the clock edge following e. meas_count equals the number of clk cycles between two consecutive e pulses.
- After reset or timeout, the first result appears on the third counted edge.
- Reporting rate: with both edges counting, a steady input of half-period H cycles reports H every H cycles.
- Timeout: meas_timeout is high for exactly one cycle, TIMEOUT cycles after the last e in ARM or COUNT.
- Simultaneous e and timeout in the same cycle: e wins, no timeout.
- meas_count is stable whenever meas_valid is high and no publish with meas_ack occurs.

## Configuration
- CLK_MEAS_FULL_PERIOD_EN
  - Defined: e = sync_out AND NOT history (rising edges only). meas_count is the full period; a divider with count N gives 2N.
  - Undefined: both edges are detected and meas_count is the half-period; a divider with count N gives N.
- All other behaviour is identical in both builds.

## Test plan
- Basic measurement:
  - Stimulus: reset, then sig_in toggling every 5 clk cycles, meas_ack tied high.
  - Response: meas_valid first asserts after the third detected edge with meas_count = 5. meas_count stays 5 thereafter.
  - With CLK_MEAS_FULL_PERIOD_EN defined, meas_count = 10.
- Overrun:
  - Stimulus: toggle every 7 cycles, meas_ack held low.
  - Response: the first result (7) is held. meas_overrun goes high at the next publish. meas_count stays 7.
  - Then pulse meas_ack: meas_valid drops one cycle later, and the next result 7 loads.
- Simultaneous ack and publish:
  - Stimulus: assert meas_ack exactly on the cycle of e.
  - Response: meas_valid remains 1, meas_count takes the new value, meas_overrun stays 0.
- Timeout:
  - Stimulus: TIMEOUT = 20; toggle every 4 cycles, then hold sig_in.
  - Response: meas_timeout pulses for 1 cycle, 20 cycles after the last e. The state returns to IDLE.
  - Resuming toggles every 4 cycles yields meas_count = 4 only after the third edge.
- Reset mid-operation:
  - Stimulus: assert clk_rst for 1 cycle while in COUNT with meas_valid = 1 and meas_overrun = 1.
  - Response: all outputs are 0 on the next cycle.
  - Toggling with a half-period of 3 then yields the first meas_count = 3 on the third edge.
- Rate change:
  - Stimulus: half-period 6, then switch to half-period 9 without reset.
  - Response: one transitional value (between 6 and 9, inclusive), then steady 9s. No timeout or overrun occurs while acked.
